// File: rtl/nx_axi4s_pkg.sv
// Shared definitions for the Nexus AXI4-stream packer and bridge.
// A slot is 32 bits: bit 31 flags a valid message, bits 30:0 carry it.
package nx_axi4s_pkg;

  localparam int NX_SLOT_WIDTH     = 32;
  localparam int NX_SLOT_VALID_BIT = 31;
  localparam int NX_MSG_WIDTH      = 31;

  typedef struct packed {
    logic                    valid;
    logic [NX_MSG_WIDTH-1:0] msg;
  } nx_slot_t;

  // Build an occupied slot from a raw Nexus message.
  function automatic nx_slot_t nx_make_slot(input logic [NX_MSG_WIDTH-1:0] msg);
    logic [NX_SLOT_WIDTH-1:0] raw;
    raw                             = '0;
    raw[NX_SLOT_VALID_BIT]          = 1'b1;
    raw[NX_SLOT_VALID_BIT-1:0]      = msg;
    return nx_slot_t'(raw);
  endfunction

endpackage

// File: rtl/nx_axi4s_packer_if.sv
// Bundle of the packer's message input, flush control, AXI4-stream output
// and idle status. The master side is the host/test logic, the slave side
// is the packer itself.
interface nx_axi4s_packer_if #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int MESSAGE_WIDTH   = 31
);

  logic [MESSAGE_WIDTH-1:0]   ib_nx_data;
  logic                       ib_nx_valid;
  logic                       ib_nx_ready;
  logic                       flush;
  logic [AXI4_DATA_WIDTH-1:0] ob_axi4s_tdata;
  logic                       ob_axi4s_tlast;
  logic                       ob_axi4s_tvalid;
  logic                       ob_axi4s_tready;
  logic                       idle;

  modport master (
    output ib_nx_data, ib_nx_valid, flush, ob_axi4s_tready,
    input  ib_nx_ready, ob_axi4s_tdata, ob_axi4s_tlast, ob_axi4s_tvalid, idle
  );

  modport slave (
    input  ib_nx_data, ib_nx_valid, flush, ob_axi4s_tready,
    output ib_nx_ready, ob_axi4s_tdata, ob_axi4s_tlast, ob_axi4s_tvalid, idle
  );

endinterface

// File: rtl/nx_axi4s_beat_reg.sv
// Output holding register for the packed AXI4-stream beat. A beat is
// loaded whenever the register is empty or is being drained this cycle,
// and is held unchanged while the consumer stalls.
module nx_axi4s_beat_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  tready,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output logic                  tvalid,
  output logic                  can_load
);

  // A new beat may land when nothing is held or the held beat leaves now.
  always_comb begin
    can_load = !tvalid || tready;
  end

  // Hold/load the beat; valid drops after a handshake with nothing new.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tdata  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tlast  <= load_last;
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/nx_axi4s_packer.sv
// Packs 31-bit Nexus messages into AXI4-stream beats of SLOTS 32-bit slots.
// Beats go out when full, after FLUSH_CYCLES idle cycles, or on flush; the
// last two cases and every MAX_BEATS-th beat close the packet with tlast.
module nx_axi4s_packer
  import nx_axi4s_pkg::*;
#(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int MESSAGE_WIDTH   = 31,
  parameter int FLUSH_CYCLES    = 16,
  parameter int MAX_BEATS       = 8
) (
  input logic clk_i,
  input logic rst_i,
  nx_axi4s_packer_if.slave bus
);

  localparam int SLOTS  = AXI4_DATA_WIDTH / NX_SLOT_WIDTH;
  localparam int FILL_W = $clog2(SLOTS + 1);
  localparam int IDLE_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic [AXI4_DATA_WIDTH-1:0] stage_q, stage_d, beat_data;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [MESSAGE_WIDTH-1:0]   in_msg;
  nx_slot_t                   in_slot;
  logic full, timeout, flush_fire, merge, send, transfer;
  logic accept, ready, beat_last, out_free;
  logic out_tvalid;

  assign in_msg  = bus.ib_nx_data;
  assign in_slot = nx_make_slot(in_msg);

  // Send/transfer decode; a message completing the beat is merged into it
  // directly so the beat leaves one cycle after that message is accepted.
  always_comb begin
    full       = (fill_q == FILL_W'(SLOTS));
    timeout    = (fill_q != '0) && (idle_q == IDLE_W'(FLUSH_CYCLES - 1));
    flush_fire = (fill_q != '0) && bus.flush;
    merge      = (fill_q == FILL_W'(SLOTS - 1)) && bus.ib_nx_valid
                 && !flush_fire && !timeout;
    send       = full || timeout || flush_fire || merge;
    transfer   = send && out_free;
    ready      = !rst_i && (!full || transfer);
    accept     = bus.ib_nx_valid && ready;
    beat_last  = flush_fire || timeout || (beat_q == BEAT_W'(MAX_BEATS - 1));
    beat_data  = stage_q;
    if (merge) begin
      beat_data[(SLOTS-1)*NX_SLOT_WIDTH +: NX_SLOT_WIDTH] = in_slot;
    end
  end

  // Next staging contents, fill level, idle timer and packet beat count.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    idle_d  = idle_q;
    beat_d  = beat_q;
    if (transfer) begin
      stage_d = '0;
      fill_d  = '0;
      if (accept && !merge) begin
        stage_d[NX_SLOT_WIDTH-1:0] = in_slot;
        fill_d                     = FILL_W'(1);
      end
    end else if (accept) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (fill_q == FILL_W'(i)) begin
          stage_d[i*NX_SLOT_WIDTH +: NX_SLOT_WIDTH] = in_slot;
        end
      end
      fill_d = fill_q + FILL_W'(1);
    end
    if (accept || transfer || (fill_q == '0)) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(FLUSH_CYCLES - 1)) begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (transfer) begin
      beat_d = beat_last ? '0 : beat_q + BEAT_W'(1);
    end
  end

  // Staging and counter registers; reset discards any partial beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
      fill_q  <= '0;
      idle_q  <= '0;
      beat_q  <= '0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      idle_q  <= idle_d;
      beat_q  <= beat_d;
    end
  end

  nx_axi4s_beat_reg #(
    .DATA_WIDTH(AXI4_DATA_WIDTH)
  ) u_beat_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (transfer),
    .load_data(beat_data),
    .load_last(beat_last),
    .tready   (bus.ob_axi4s_tready),
    .tdata    (bus.ob_axi4s_tdata),
    .tlast    (bus.ob_axi4s_tlast),
    .tvalid   (out_tvalid),
    .can_load (out_free)
  );

  assign bus.ob_axi4s_tvalid = out_tvalid;
  assign bus.ib_nx_ready     = ready;
  assign bus.idle            = (fill_q == '0) && !out_tvalid;

endmodule

// File: tb/tb_nx_axi4s_packer.sv
// Scoreboard bench for nx_axi4s_packer (64-bit beats, 16-cycle flush
// timeout, 8 beats per packet). Stimulus pushes expected beats; a monitor
// pops and compares on every output handshake.
module tb_nx_axi4s_packer;

  logic clk;
  logic rst;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    stall_cycles = 0;

  nx_axi4s_packer_if #(.AXI4_DATA_WIDTH(64), .MESSAGE_WIDTH(31)) bus ();

  nx_axi4s_packer #(
    .AXI4_DATA_WIDTH(64),
    .MESSAGE_WIDTH  (31),
    .FLUSH_CYCLES   (16),
    .MAX_BEATS      (8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] pack2(input logic [30:0] hi, input logic [30:0] lo);
    return {1'b1, hi, 1'b1, lo};
  endfunction

  function automatic logic [63:0] pack1(input logic [30:0] lo);
    return {32'h0, 1'b1, lo};
  endfunction

  // Offer one message and hold it until accepted (bounded).
  task automatic apply_stimulus(input logic [30:0] m);
    int waited;
    waited          = 0;
    bus.ib_nx_data  = m;
    bus.ib_nx_valid = 1'b1;
    @(negedge clk);
    while (!bus.ib_nx_ready && waited < 200) begin
      waited++;
      stall_cycles++;
      @(negedge clk);
    end
    if (!bus.ib_nx_ready) check_output("accept_timeout", 64'(waited), 64'd0);
    @(posedge clk);
    #1;
    bus.ib_nx_valid = 1'b0;
  endtask

  // Wait until every expected beat is consumed and the packer is idle.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || !bus.idle) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output(name, 64'(n < 100), 64'd1);
  endtask

  // Monitor: compare each handshaken beat against the scoreboard head.
  initial begin
    beat_t exp_b;
    forever begin
      @(negedge clk);
      if (!rst && bus.ob_axi4s_tvalid && bus.ob_axi4s_tready) begin
        if (sb.size() == 0) begin
          check_output("unexpected_beat", bus.ob_axi4s_tdata, 64'hDEAD);
        end else begin
          exp_b = sb.pop_front();
          check_output("beat_tdata", bus.ob_axi4s_tdata, exp_b.data);
          check_output("beat_tlast", 64'(bus.ob_axi4s_tlast), 64'(exp_b.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [30:0] m;
    rst                 = 1'b1;
    bus.ib_nx_data      = '0;
    bus.ib_nx_valid     = 1'b0;
    bus.flush           = 1'b0;
    bus.ob_axi4s_tready = 1'b1;

    // Reset state
    #1;
    check_output("rst_tvalid", 64'(bus.ob_axi4s_tvalid), 64'd0);
    check_output("rst_idle", 64'(bus.idle), 64'd1);
    check_output("rst_ready", 64'(bus.ib_nx_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_output("post_rst_ready", 64'(bus.ib_nx_ready), 64'd1);

    // Two messages form one full beat, tvalid right after the 2nd accept
    sb.push_back('{data: 64'h80000002_80000001, last: 1'b0});
    apply_stimulus(31'h1);
    apply_stimulus(31'h2);
    check_output("t1_latency_tvalid", 64'(bus.ob_axi4s_tvalid), 64'd1);
    drain("t1_drain");

    // Single message leaves by timeout with tlast, 16 cycles after accept
    sb.push_back('{data: 64'h00000000_FFFFFFFF, last: 1'b1});
    apply_stimulus(31'h7FFFFFFF);
    check_output("t2_not_idle", 64'(bus.idle), 64'd0);
    n = 0;
    while (!bus.ob_axi4s_tvalid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("t2_timeout_cycles", 64'(n), 64'd16);
    drain("t2_drain");

    // 16 continuous messages: 8 beats, tlast only on the 8th
    stall_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      m = 31'h100 + 31'(2 * k);
      sb.push_back('{data: pack2(m + 31'h1, m), last: (k == 7)});
      apply_stimulus(m);
      apply_stimulus(m + 31'h1);
    end
    check_output("t3_ready_never_low", 64'(stall_cycles), 64'd0);
    drain("t3_drain");

    // Back-pressure: beat held, staging fills, ready drops, then resume
    bus.ob_axi4s_tready = 1'b0;
    sb.push_back('{data: pack2(31'h0B, 31'h0A), last: 1'b0});
    apply_stimulus(31'h0A);
    apply_stimulus(31'h0B);
    sb.push_back('{data: pack2(31'h0D, 31'h0C), last: 1'b0});
    apply_stimulus(31'h0C);
    apply_stimulus(31'h0D);
    check_output("t4_ready_low", 64'(bus.ib_nx_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_output("t4_hold_tvalid", 64'(bus.ob_axi4s_tvalid), 64'd1);
    check_output("t4_hold_tdata", bus.ob_axi4s_tdata, pack2(31'h0B, 31'h0A));
    check_output("t4_still_not_ready", 64'(bus.ib_nx_ready), 64'd0);
    bus.ob_axi4s_tready = 1'b1;
    sb.push_back('{data: pack2(31'h0F, 31'h0E), last: 1'b0});
    apply_stimulus(31'h0E);
    apply_stimulus(31'h0F);
    drain("t4_drain");

    // Flush with fill=1 and an accept in the same cycle
    sb.push_back('{data: pack1(31'h11), last: 1'b1});
    apply_stimulus(31'h11);
    bus.flush       = 1'b1;
    bus.ib_nx_data  = 31'h22;
    bus.ib_nx_valid = 1'b1;
    @(negedge clk);
    check_output("t5_ready_with_flush", 64'(bus.ib_nx_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.flush       = 1'b0;
    bus.ib_nx_valid = 1'b0;
    sb.push_back('{data: pack2(31'h33, 31'h22), last: 1'b0});
    apply_stimulus(31'h33);
    drain("t5_drain");

    // Asynchronous reset mid-packet while a beat is pending
    bus.ob_axi4s_tready = 1'b0;
    apply_stimulus(31'h44);
    apply_stimulus(31'h55);
    apply_stimulus(31'h66);
    check_output("t6_pending_tvalid", 64'(bus.ob_axi4s_tvalid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_output("t6_rst_tvalid", 64'(bus.ob_axi4s_tvalid), 64'd0);
    check_output("t6_rst_tlast", 64'(bus.ob_axi4s_tlast), 64'd0);
    check_output("t6_rst_tdata", bus.ob_axi4s_tdata, 64'd0);
    check_output("t6_rst_idle", 64'(bus.idle), 64'd1);
    check_output("t6_rst_ready", 64'(bus.ib_nx_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst                 = 1'b0;
    bus.ob_axi4s_tready = 1'b1;
    #1;
    check_output("t6_release_ready", 64'(bus.ib_nx_ready), 64'd1);
    for (int k = 0; k < 8; k++) begin
      m = 31'h200 + 31'(2 * k);
      sb.push_back('{data: pack2(m + 31'h1, m), last: (k == 7)});
      apply_stimulus(m);
      apply_stimulus(m + 31'h1);
    end
    drain("t6_drain");

    check_output("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
